carry_select_subtractor_seq32: RTL and testbench

CARRY_SELECT_SUBTRACTOR_SEQ32 -- requirements
Module: carry_select_subtractor_seq32

---
 rtl/carry_select_subtractor_seq32.sv | 130 +++++++++++++
 tb/tb_carry_select_subtractor_seq32.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_select_subtractor_seq32.sv
`default_nettype none
// ============================================================================
//  Module      : carry_select_subtractor_seq32
//  Description : Sequential 32-bit subtractor (a - b). The operands are
//                latched on start and processed one 8-bit slice per cycle,
//                LSB slice first. Each slice precomputes a_i + ~b_i for both
//                carry-in values and selects with the registered carry.
//                Latency: start sampled at edge k, done during the cycle
//                after edge k+4.
//  Revision    : 1.0 - initial release
// ============================================================================
module carry_select_subtractor_seq32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] c_LAST_SLICE = 2'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic        r_carry;
  logic [31:0] r_a;
  logic [31:0] r_b;

  logic [7:0]  w_a_sl;
  logic [7:0]  w_b_sl;
  logic [8:0]  w_sum0;
  logic [8:0]  w_sum1;
  logic [8:0]  w_sel;

  // Current slice operands: {r_cnt, 3'b000} is the slice's base bit index.
  assign w_a_sl = r_a[{r_cnt, 3'b000} +: 8];
  assign w_b_sl = r_b[{r_cnt, 3'b000} +: 8];

  // Both carry-in candidates are formed in parallel; the registered carry
  // only drives the final select, which is the carry-select structure.
  assign w_sum0 = {1'b0, w_a_sl} + {1'b0, ~w_b_sl};
  assign w_sum1 = {1'b0, w_a_sl} + {1'b0, ~w_b_sl} + 9'd1;
  assign w_sel  = r_carry ? w_sum1 : w_sum0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs; start is only honoured in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == c_LAST_SLICE) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand latch on accept, one slice per CALC cycle, flags on
  // the last slice. Results are left untouched outside CALC so they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_cnt   <= 2'd0;
      r_carry <= 1'b0;
      diff    <= 32'd0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= 2'd0;
            r_carry <= 1'b1;
          end
        end
        S_CALC: begin
          diff[{r_cnt, 3'b000} +: 8] <= w_sel[7:0];
          r_carry <= w_sel[8];
          r_cnt   <= r_cnt + 2'd1;
          if (r_cnt == c_LAST_SLICE) begin
            // A missing carry out of the MSB slice means a < b unsigned.
            borrow <= ~w_sel[8];
            ovf    <= (r_a[31] != r_b[31]) && (w_sel[7] != r_a[31]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_carry_select_subtractor_seq32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_select_subtractor_seq32
//  Description : Self-checking bench for carry_select_subtractor_seq32 with a
//                cycle-level behavioural model and directed literal cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_carry_select_subtractor_seq32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] diff;
  logic        borrow;
  logic        ovf;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;
  logic go = 1'b0;

  carry_select_subtractor_seq32 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1..4 = computing, 5 = result valid.
  int          m_phase = 0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;
  logic [31:0] m_diff = 32'd0;
  logic        m_borrow = 1'b0;
  logic        m_ovf = 1'b0;

  function automatic logic m_ovf_of(input logic [31:0] x, input logic [31:0] y);
    longint d;
    d = longint'($signed(x)) - longint'($signed(y));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = 0;
      m_diff   = 32'd0;
      m_borrow = 1'b0;
      m_ovf    = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_a     = a;
        m_b     = b;
        m_phase = 1;
      end
    end else if (m_phase < 5) begin
      m_phase = m_phase + 1;
      if (m_phase == 5) begin
        m_diff   = m_a - m_b;
        m_borrow = (m_a < m_b);
        m_ovf    = m_ovf_of(m_a, m_b);
      end
    end else begin
      m_phase = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (go) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_phase >= 1 && m_phase <= 4)});
      chk("done", {31'd0, done}, {31'd0, (m_phase == 5)});
      if (m_phase == 0 || m_phase == 5) begin
        chk("diff",   diff,            m_diff);
        chk("borrow", {31'd0, borrow}, {31'd0, m_borrow});
        chk("ovf",    {31'd0, ovf},    {31'd0, m_ovf});
      end
    end
  end

  // Wait for done with a bound; returns number of negedges waited and busy count.
  task automatic wait_done(input string nm, output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!done && n < 12) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end
  endtask

  // One operation with hand-computed expectations; operands are scrambled
  // right after acceptance to show the latched values are used.
  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic [31:0] ed, input logic eb, input logic eo,
                        input logic chk_busy);
    int n, bc;
    @(negedge clk);
    a = ta; b = tb2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(nm, n, bc);
    if (done) begin
      chk({nm, "_diff"},   diff, ed);
      chk({nm, "_borrow"}, {31'd0, borrow}, {31'd0, eb});
      chk({nm, "_ovf"},    {31'd0, ovf},    {31'd0, eo});
      chk({nm, "_model"},  m_diff, ed);
      chk({nm, "_lat"},    n, 4);
      if (chk_busy) chk({nm, "_busycyc"}, bc, 4);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bc, dones;
    rst = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    go = 1'b1;
    chk("rst_diff", diff, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    run_op("zero",   32'h0,        32'h0,        32'h0000_0000, 1'b0, 1'b0, 1'b1);
    run_op("seq1",   32'h13,       32'h02,       32'h11,        1'b0, 1'b0, 1'b0);
    run_op("seq2",   32'h18,       32'h08,       32'h10,        1'b0, 1'b0, 1'b0);
    run_op("seq3",   32'h30,       32'h04,       32'h2C,        1'b0, 1'b0, 1'b0);
    run_op("neg1",   32'h0,        32'h1,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("chain",  32'h0000_00FF,32'hFFFF_FF00,32'h0000_01FF, 1'b1, 1'b0, 1'b0);
    run_op("ovfneg", 32'h8000_0000,32'h0000_0001,32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("ovfpos", 32'h7FFF_FFFF,32'hFFFF_FFFF,32'h8000_0000, 1'b1, 1'b1, 1'b0);

    // Start re-pulsed two cycles into CALC must be ignored.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0000_1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", n, bc);
    if (done) chk("ign_diff", diff, 32'h1234_4567);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ign_single_done", dones, 0);

    // Reset on the third CALC cycle aborts the operation.
    @(negedge clk);
    a = 32'h0000_0100; b = 32'h0000_0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_diff",   diff, 32'd0);
    chk("abort_borrow", {31'd0, borrow}, 32'd0);
    chk("abort_ovf",    {31'd0, ovf},    32'd0);
    chk("abort_busy",   {31'd0, busy},   32'd0);
    chk("abort_done",   {31'd0, done},   32'd0);
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_nodone", dones, 0);
    run_op("post_rst", 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1'b0);

    // Start held high: one operation every 6 cycles.
    @(negedge clk);
    start = 1'b1; a = pick(); b = pick();
    dones = 0;
    repeat (24) begin
      @(negedge clk);
      a = pick(); b = pick();
      if (done) dones++;
    end
    start = 1'b0;
    chk("b2b_dones", dones, 4);
    repeat (3) @(negedge clk);

    // Randomized operations with random gaps, checked by the model.
    repeat (40) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = pick(); b = pick(); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if ($urandom_range(0, 1) == 1) start = 1'b1;
      a = $urandom; b = $urandom;
      wait_done("rnd", n, bc);
      start = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
